// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The FSM encoding and the write-enable decode helper live here.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   wr_en_t;

  // Register 0 may be hardwired; its write is still granted but does nothing.
  function automatic wr_en_t decode_wr_en(input reg_addr_t addr, input bit zero_writable);
    wr_en_t onehot;
    onehot = wr_en_t'(1) << addr;
    if ((addr == '0) && !zero_writable) begin
      onehot = '0;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/grant bus between the writeback requesters and the write arbiter.
// The master side drives requests; the slave side is the arbiter.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);

  logic                          enable;
  logic [NUM_REQ-1:0]            req;
  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [DATA_W*NUM_REQ-1:0]     req_data;

  logic [NUM_REQ-1:0]            gnt;
  wr_en_t                        wr_en;
  reg_addr_t                     wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic                          busy;
  logic [15:0]                   write_count;

  modport master (
    output enable, req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, busy, write_count
  );

  modport slave (
    input  enable, req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, busy, write_count
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at or after
// start_idx, wrapping modulo NUM_REQ.
module regfile_write_arbiter_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   start_idx,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W:0]     pos;

  // One extra bit on pos lets start_idx + i be reduced modulo NUM_REQ
  // even when NUM_REQ is not a power of two.
  always_comb begin
    eligible = req & ~mask;
    found    = 1'b0;
    winner   = '0;
    pos      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, start_idx} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && eligible[pos[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single 8-entry register-file write port.
// Every output is registered; a grant is a one-cycle WRITE pulse.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int DATA_W            = 16,
  parameter bit ZERO_REG_WRITABLE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  state_e              state_q, state_d;
  idx_t                last_q, last_d;
  idx_t                win_q, win_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  wr_en_t              wr_en_q, wr_en_d;
  reg_addr_t           wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [15:0]         write_count_q, write_count_d;

  reg_addr_t           addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  idx_t                cur_last;
  idx_t                start_idx;
  logic [NUM_REQ-1:0]  mask;
  logic                found;
  idx_t                pick;
  logic                take;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*REG_ADDR_W +: REG_ADDR_W];
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // While a grant is in flight its requester may still hold req high, so
  // it is masked and the scan restarts just past it.
  always_comb begin
    cur_last  = (state_q == ST_WRITE) ? win_q : last_q;
    start_idx = (cur_last == idx_t'(NUM_REQ-1)) ? '0 : cur_last + idx_t'(1);
    mask      = (state_q == ST_WRITE) ? (NUM_REQ'(1) << win_q) : '0;
  end

  regfile_write_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) rr_pick (
    .req       (bus.req),
    .mask      (mask),
    .start_idx (start_idx),
    .found     (found),
    .winner    (pick)
  );

  assign take = bus.enable && found;

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // so the order of the sequential blocks never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // IDLE and WRITE share one rule: capture a winner if one exists.
  always_comb begin
    state_d = take ? ST_WRITE : ST_IDLE;
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    gnt_d         = '0;
    wr_en_d       = '0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    win_d         = win_q;
    last_d        = last_q;
    write_count_d = write_count_q;

    if (take) begin
      gnt_d     = NUM_REQ'(1) << pick;
      wr_addr_d = addr_arr[pick];
      wr_data_d = data_arr[pick];
      wr_en_d   = decode_wr_en(addr_arr[pick], ZERO_REG_WRITABLE);
      win_d     = pick;
    end

    // The write commits as the WRITE cycle ends; a reset inside it loses it.
    if (state_q == ST_WRITE) begin
      last_d = win_q;
      if (wr_en_q != '0) begin
        write_count_d = write_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= idx_t'(NUM_REQ-1);
      win_q         <= '0;
      gnt_q         <= '0;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      write_count_q <= '0;
    end else begin
      last_q        <= last_d;
      win_q         <= win_d;
      gnt_q         <= gnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      write_count_q <= write_count_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = (state_q == ST_WRITE);
  assign bus.write_count = write_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a 4-requester instance with a
// hardwired register 0, plus a 2-requester instance where register 0 is writable.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus0 ();
  regfile_write_arbiter_if #(.NUM_REQ(2),  .DATA_W(DW)) bus1 ();

  regfile_write_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ZERO_REG_WRITABLE(1'b0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  regfile_write_arbiter #(
    .NUM_REQ(2), .DATA_W(DW), .ZERO_REG_WRITABLE(1'b1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [15:0] d);
    bus0.req_addr[i*3 +: 3]   = a;
    bus0.req_data[i*DW +: DW] = d;
  endtask

  int exp_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int exp_cnt;
  int w;
  logic reached;

  initial begin
    bus0.enable = 1'b0; bus0.req = '0; bus0.req_addr = '0; bus0.req_data = '0;
    bus1.enable = 1'b0; bus1.req = '0; bus1.req_addr = '0; bus1.req_data = '0;

    // Reset state, observed while rst_n is still low
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt",   32'(bus0.gnt), 32'h0);
    check("rst_wr_en", 32'(bus0.wr_en), 32'h0);
    check("rst_addr",  32'(bus0.wr_addr), 32'h0);
    check("rst_data",  32'(bus0.wr_data), 32'h0);
    check("rst_busy",  32'(bus0.busy), 32'h0);
    check("rst_count", 32'(bus0.write_count), 32'h0);
    #1 rst_n = 1'b1;
    tick();

    // Single request: reg 5 <- ABCD
    bus0.enable = 1'b1;
    set_req(0, 3'd5, 16'hABCD);
    bus0.req = 4'b0001;
    tick();
    check("single_gnt",   32'(bus0.gnt), 32'h1);
    check("single_wr_en", 32'(bus0.wr_en), 32'h20);
    check("single_addr",  32'(bus0.wr_addr), 32'h5);
    check("single_data",  32'(bus0.wr_data), 32'hABCD);
    check("single_busy",  32'(bus0.busy), 32'h1);
    bus0.req = 4'b0000;
    tick();
    check("single_count", 32'(bus0.write_count), 32'h1);
    check("single_idle",  32'(bus0.busy), 32'h0);
    check("single_gnt0",  32'(bus0.gnt), 32'h0);

    // Fairness: all four requesting, requester 0 was served last
    for (int i = 0; i < NR; i++) set_req(i, 3'(i + 1), 16'(16'h1000 + i));
    bus0.req = 4'b1111;
    exp_cnt = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      w = exp_order[k];
      check("rr_gnt",   32'(bus0.gnt), 32'(1) << w);
      check("rr_wr_en", 32'(bus0.wr_en), 32'(1) << (w + 1));
      check("rr_data",  32'(bus0.wr_data), 32'(16'h1000 + w));
      check("rr_count", 32'(bus0.write_count), 32'(exp_cnt));
      exp_cnt++;
    end
    bus0.req = 4'b0000;
    tick();
    check("rr_done_busy",  32'(bus0.busy), 32'h0);
    check("rr_done_count", 32'(bus0.write_count), 32'd9);

    // Zero register: suppressed on dut0, written on dut1
    set_req(0, 3'd0, 16'h5555);
    bus0.req = 4'b0001;
    bus1.enable = 1'b1;
    bus1.req_addr = '0;
    bus1.req_data[15:0] = 16'h5555;
    bus1.req = 2'b01;
    tick();
    check("zero_gnt",    32'(bus0.gnt), 32'h1);
    check("zero_wr_en",  32'(bus0.wr_en), 32'h0);
    check("zero_busy",   32'(bus0.busy), 32'h1);
    check("zero1_gnt",   32'(bus1.gnt), 32'h1);
    check("zero1_wr_en", 32'(bus1.wr_en), 32'h01);
    bus0.req = 4'b0000;
    bus1.req = 2'b00;
    tick();
    check("zero_count",  32'(bus0.write_count), 32'd9);
    check("zero1_count", 32'(bus1.write_count), 32'd1);

    // Enable gating
    set_req(0, 3'd5, 16'hABCD);
    set_req(1, 3'd3, 16'h3333);
    set_req(2, 3'd4, 16'h4444);
    bus0.enable = 1'b0;
    bus0.req = 4'b0110;
    repeat (3) begin
      tick();
      check("en_off_gnt",  32'(bus0.gnt), 32'h0);
      check("en_off_busy", 32'(bus0.busy), 32'h0);
    end
    bus0.enable = 1'b1;
    tick();
    check("en_on_gnt",   32'(bus0.gnt), 32'b0010);
    check("en_on_wr_en", 32'(bus0.wr_en), 32'h08);
    check("en_on_data",  32'(bus0.wr_data), 32'h3333);
    bus0.enable = 1'b0;
    bus0.req = 4'b0100;
    tick();
    check("en_drop_gnt",   32'(bus0.gnt), 32'h0);
    check("en_drop_busy",  32'(bus0.busy), 32'h0);
    check("en_drop_count", 32'(bus0.write_count), 32'd10);
    tick();
    check("en_drop_gnt2",  32'(bus0.gnt), 32'h0);
    bus0.req = 4'b0000;
    bus0.enable = 1'b1;
    tick();

    // Async reset in the middle of a WRITE
    set_req(3, 3'd7, 16'h7777);
    bus0.req = 4'b1000;
    tick();
    check("ar_gnt",   32'(bus0.gnt), 32'b1000);
    check("ar_wr_en", 32'(bus0.wr_en), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    check("ar_rst_gnt",   32'(bus0.gnt), 32'h0);
    check("ar_rst_wr_en", 32'(bus0.wr_en), 32'h0);
    check("ar_rst_busy",  32'(bus0.busy), 32'h0);
    check("ar_rst_count", 32'(bus0.write_count), 32'h0);
    bus0.req = 4'b0000;
    #2 rst_n = 1'b1;
    bus0.req = 4'b1111;
    tick();
    check("ar_first_gnt", 32'(bus0.gnt), 32'b0001);

    // Counter wrap: keep a grant every cycle until the count hits FFFF
    reached = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      if (bus0.write_count == 16'hFFFF) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("wrap_reach_ffff", 32'(reached), 32'h1);
    tick();
    check("wrap_zero", 32'(bus0.write_count), 32'h0);
    bus0.req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
